// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display controller: font table,
// blank pattern and sizing helpers.
package seg_pkg;

  localparam int SUB_PHASES = 16;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}; dp bit left high (off) in every entry.
  localparam logic [7:0] SEG_FONT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic int scan_width(input int digits);
    return $clog2(digits);
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble + decimal point to active-low cathode pattern.
module seg_hex_decode (
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] cathode
);
  import seg_pkg::*;

  logic [7:0] font;

  always_comb begin
    font    = SEG_FONT[nibble];
    cathode = {font[7] & ~dp, font[6:0]};
  end

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed common-anode seven-segment controller with frame-atomic
// loads, decimal points, leading-zero blanking and 16-level PWM brightness.
module seg_display_mux #(
  parameter int DIGITS     = 4,
  parameter int SUB_CYCLES = 6250
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic [3:0]            bright,
  output logic [DIGITS-1:0]     anode,
  output logic [7:0]            cathode,
  output logic                  frame_done
);
  import seg_pkg::*;

  localparam int SCAN_W = scan_width(DIGITS);
  localparam int SUB_W  = (SUB_CYCLES > 1) ? $clog2(SUB_CYCLES) : 1;
  localparam logic [SUB_W-1:0]  SUB_LAST   = SUB_W'(SUB_CYCLES - 1);
  localparam logic [3:0]        PHASE_LAST = 4'(SUB_PHASES - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(DIGITS - 1);

  logic [SUB_W-1:0]    sub_cnt;
  logic [3:0]          phase;
  logic [SCAN_W-1:0]   scan;
  logic [3:0]          bright_q;

  logic [4*DIGITS-1:0] pending_val;
  logic [DIGITS-1:0]   pending_dp;
  logic                pend_flag;
  logic [4*DIGITS-1:0] shadow_val;
  logic [DIGITS-1:0]   shadow_dp;

  logic                sub_wrap;
  logic                phase_wrap;
  logic                frame_end;
  logic [DIGITS-1:0]   blank_vec;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                show;
  logic [7:0]          dec_cath;

  assign sub_wrap   = (sub_cnt == SUB_LAST);
  assign phase_wrap = sub_wrap && (phase == PHASE_LAST);
  assign frame_end  = phase_wrap && (scan == SCAN_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_cnt  <= '0;
      phase    <= '0;
      scan     <= '0;
      bright_q <= '0;
    end else begin
      sub_cnt <= sub_wrap ? '0 : sub_cnt + 1'b1;
      if (sub_wrap)
        phase <= phase + 1'b1;
      if (phase_wrap)
        scan <= frame_end ? '0 : scan + 1'b1;
      if (phase == '0 && sub_cnt == '0)
        bright_q <= bright;
    end
  end

  // A load landing on the boundary cycle replaces pending and keeps the
  // flag set, so the previously pending data is dropped rather than shown.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_val <= '0;
      pending_dp  <= '0;
      pend_flag   <= 1'b0;
      shadow_val  <= '0;
      shadow_dp   <= '0;
    end else begin
      if (load) begin
        pending_val <= value;
        pending_dp  <= dp_in;
        pend_flag   <= 1'b1;
      end else if (frame_end && pend_flag) begin
        shadow_val <= pending_val;
        shadow_dp  <= pending_dp;
        pend_flag  <= 1'b0;
      end
    end
  end

  // Walk from the most significant digit down, tracking "everything at or
  // above k is zero with no dp"; digit 0 is never blanked.
  always_comb begin
    logic z;
    int unsigned k;
    z         = 1'b1;
    k         = 0;
    blank_vec = '0;
    for (int unsigned i = DIGITS; i > 0; i--) begin
      k = i - 1;
      z = z & (shadow_val[k*4 +: 4] == 4'h0) & ~shadow_dp[k];
      if (k != 0)
        blank_vec[k] = blank_lz & z;
    end
  end

  assign cur_nib = shadow_val[scan*4 +: 4];
  assign cur_dp  = shadow_dp[scan];
  assign show    = (phase <= bright_q) && !blank_vec[scan];

  seg_hex_decode u_dec (
    .nibble  (cur_nib),
    .dp      (cur_dp),
    .cathode (dec_cath)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      anode      <= '1;
      cathode    <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (show) begin
        anode   <= ~(DIGITS'(1) << scan);
        cathode <= dec_cath;
      end else begin
        anode   <= '1;
        cathode <= SEG_BLANK;
      end
    end
  end

endmodule
